datapath_sequencer: RTL

- Multi-cycle control FSM directly upstream of the register-file/ALU/RAM datapath.
- Accepts one 32-bit instruction per valid/ready handshake.
- Expands each instruction into the datapath control word across DECODE/EXEC/MEM/WB cycles: register selects, function select, carry-in, write enables, constant and mux selects.
- Latches ALU status flags and counts retired instructions.

---
 rtl/datapath_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: expands one handshaked 32-bit instruction into the
// register-file/ALU/RAM control word over DECODE, EXEC, MEM and WB cycles.
module datapath_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR = 5,
    parameter int FS_WIDTH = 5,
    parameter logic [FS_WIDTH-1:0] FS_ADD = FS_WIDTH'(5'b01000),
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    input  logic [3:0]            SIGNAL,
    output logic [REG_ADDR-1:0]   A,
    output logic [REG_ADDR-1:0]   B,
    output logic [REG_ADDR-1:0]   regSel,
    output logic [FS_WIDTH-1:0]   FS,
    output logic                  CO,
    output logic                  const_sel,
    output logic [DATA_WIDTH-1:0] K,
    output logic                  wrt,
    output logic                  RAMwrt,
    output logic                  muxSelect,
    output logic                  busy,
    output logic [3:0]            flags,
    output logic [CNT_WIDTH-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t     state;
    logic [1:0] op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op          <= '0;
            A           <= '0;
            B           <= '0;
            regSel      <= '0;
            FS          <= '0;
            CO          <= 1'b0;
            const_sel   <= 1'b0;
            K           <= '0;
            wrt         <= 1'b0;
            RAMwrt      <= 1'b0;
            muxSelect   <= 1'b0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            flags       <= '0;
            retired     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        state       <= S_DECODE;
                        op          <= instr[31:30];
                        A           <= REG_ADDR'(instr[19:15]);
                        B           <= REG_ADDR'(instr[14:10]);
                        regSel      <= REG_ADDR'(instr[24:20]);
                        K           <= DATA_WIDTH'(instr[8:0]);
                        // Memory ops reuse the ALU purely as an address adder.
                        FS          <= instr[31] ? FS_ADD : FS_WIDTH'(instr[29:25]);
                        CO          <= instr[31] ? 1'b0 : instr[9];
                        const_sel   <= (instr[31:30] != 2'b00);
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    flags <= SIGNAL;
                    if (op[1]) begin
                        state     <= S_MEM;
                        RAMwrt    <= op[0];
                        muxSelect <= ~op[0];
                    end else begin
                        state <= S_WB;
                        wrt   <= 1'b1;
                    end
                end
                S_MEM, S_WB: begin
                    if (state == S_MEM && !op[0]) begin
                        state  <= S_WB;
                        wrt    <= 1'b1;
                        RAMwrt <= 1'b0;
                    end else begin
                        // Retire: drop the control word and reopen the handshake.
                        state       <= S_IDLE;
                        A           <= '0;
                        B           <= '0;
                        regSel      <= '0;
                        FS          <= '0;
                        CO          <= 1'b0;
                        const_sel   <= 1'b0;
                        K           <= '0;
                        wrt         <= 1'b0;
                        RAMwrt      <= 1'b0;
                        muxSelect   <= 1'b0;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        retired     <= retired + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
